// File: rtl/des_core.sv
// Iterative single-DES engine: one Feistel round per clock, encrypt or decrypt.
// Bit 1 of every FIPS-numbered vector is the MSB of the corresponding port/register.
module des_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        enc1_dec0,
    input  logic [63:0] in,
    input  logic [63:0] key,
    output logic [63:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Permutation tables, one byte per entry, first entry in the MSBs, zero padded.
    localparam logic [511:0] IP_T = {
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
    localparam logic [511:0] FP_T = {
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
        8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
        8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
        8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
        8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
    localparam logic [511:0] E_T = {
        8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,
        8'd6,  8'd7,  8'd8,  8'd9,  8'd8,  8'd9,  8'd10, 8'd11,
        8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21,
        8'd22, 8'd23, 8'd24, 8'd25, 8'd24, 8'd25, 8'd26, 8'd27,
        8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1,
        128'd0};
    localparam logic [511:0] P_T = {
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
        8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
        8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25,
        256'd0};
    localparam logic [511:0] PC1_T = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
        8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
        8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
        8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4,
        64'd0};
    localparam logic [511:0] PC2_T = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32,
        128'd0};

    // Each S-box: 64 nibbles, index = row*16 + column, first entry in the MSBs.
    localparam logic [255:0] SBOX [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    // x holds an in_w-bit vector right-aligned; result is out_w bits right-aligned.
    function automatic logic [63:0] permute(input logic [63:0] x, input logic [511:0] tab,
                                            input int in_w, input int out_w);
        logic [63:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < out_w) begin
                src = in_w - int'(tab[9'(511 - 8 * i) -: 8]);
                y[6'(out_w - 1 - i)] = x[6'(src)];
            end
        end
        return y;
    endfunction

    function automatic logic [31:0] sbox_all(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        logic [5:0]  n;
        y = '0;
        for (int k = 0; k < 8; k++) begin
            b = x[6'(47 - 6 * k) -: 6];
            n = {b[5], b[0], b[4:1]};
            y[5'(31 - 4 * k) -: 4] = SBOX[3'(k)][8'(255 - 4 * int'(n)) -: 4];
        end
        return y;
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        mode;
    logic        load, last;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;

    logic [4:0]  sidx;
    logic        shift_one;
    logic [27:0] c_rot, d_rot;
    logic [47:0] k_rnd, e_r;
    logic [31:0] f_out, l_nxt, r_nxt;
    logic [63:0] ip_in, fp_out;
    logic [55:0] pc1_key;

    // Key rotation for the round about to run: left before encrypt rounds,
    // right after the first decrypt round (whose key is PC-2 of C0D0 itself).
    always_comb begin
        sidx      = mode ? (5'(cnt) + 5'd1) : (5'd17 - 5'(cnt));
        shift_one = (sidx == 5'd1) || (sidx == 5'd2) || (sidx == 5'd9) || (sidx == 5'd16);
        c_rot     = c_q;
        d_rot     = d_q;
        if (mode) begin
            c_rot = shift_one ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
            d_rot = shift_one ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
        end else if (cnt != 4'd0) begin
            c_rot = shift_one ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
            d_rot = shift_one ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
        end
    end

    assign k_rnd   = 48'(permute({8'd0, c_rot, d_rot}, PC2_T, 56, 48));
    assign e_r     = 48'(permute({32'd0, r_q}, E_T, 32, 48));
    assign f_out   = 32'(permute({32'd0, sbox_all(e_r ^ k_rnd)}, P_T, 32, 32));
    assign l_nxt   = r_q;
    assign r_nxt   = l_q ^ f_out;
    assign fp_out  = permute({r_nxt, l_nxt}, FP_T, 64, 64);
    assign ip_in   = permute(in, IP_T, 64, 64);
    assign pc1_key = 56'(permute(key, PC1_T, 64, 56));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == 4'd15) begin
                last      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 4'd0;
            mode <= 1'b0;
            done <= 1'b0;
            out  <= 64'd0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt  <= 4'd0;
                mode <= enc1_dec0;
            end else if (state == RUN) begin
                cnt <= cnt + 4'd1;
                if (last) begin
                    done <= 1'b1;
                    out  <= fp_out;
                end
            end
        end
    end

    // Round state: meaningful only while RUN, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            l_q <= ip_in[63:32];
            r_q <= ip_in[31:0];
            c_q <= pc1_key[55:28];
            d_q <= pc1_key[27:0];
        end else if (state == RUN) begin
            l_q <= l_nxt;
            r_q <= r_nxt;
            c_q <= c_rot;
            d_q <= d_rot;
        end
    end

endmodule

// File: tb/tb_des_core.sv
// Directed DES vectors plus abort, ignored-start and back-to-back sequences.
module tb_des_core;

    logic        clk = 1'b0;
    logic        rst, start, enc1_dec0;
    logic [63:0] in_blk, key, out;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] key;
        logic [63:0] din;
        logic        enc;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [6];

    des_core dut (
        .clk(clk), .rst(rst), .start(start), .enc1_dec0(enc1_dec0),
        .in(in_blk), .key(key), .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic kick(input vec_t v);
        key       = v.key;
        in_blk    = v.din;
        enc1_dec0 = v.enc;
        start     = 1'b1;
    endtask

    // Start is already high; the first edge is the start edge (edge 1).
    // done must first be seen high after edge 17.
    task automatic wait_done(input string name, input logic [63:0] exp, input int disturb_at);
        int edges;
        edges = 1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy"}, 64'(busy), 64'd1);
        while (done !== 1'b1 && edges < 40) begin
            if (edges == disturb_at) begin
                start     = 1'b1;
                in_blk    = {$urandom, $urandom};
                key       = {$urandom, $urandom};
                enc1_dec0 = ~enc1_dec0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        chk({name, " latency"}, 64'(edges), 64'd17);
        chk({name, " out"}, out, exp);
    endtask

    task automatic run_op(input vec_t v, input string name);
        @(negedge clk);
        kick(v);
        wait_done(name, v.exp, 0);
        @(posedge clk); #1;
        chk({name, " done pulse width"}, 64'(done), 64'd0);
        chk({name, " busy after"}, 64'(busy), 64'd0);
        chk({name, " out held"}, out, v.exp);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{key: 64'h22234512987ABB23, din: 64'h0000000000000001, enc: 1'b1, exp: 64'h0A4ED5C15A63FEA3};
        vecs[1] = '{key: 64'h22234512987ABB23, din: 64'h0A4ED5C15A63FEA3, enc: 1'b0, exp: 64'h0000000000000001};
        vecs[2] = '{key: 64'h133457799BBCDFF1, din: 64'h0123456789ABCDEF, enc: 1'b1, exp: 64'h85E813540F0AB405};
        vecs[3] = '{key: 64'h133457799BBCDFF1, din: 64'h85E813540F0AB405, enc: 1'b0, exp: 64'h0123456789ABCDEF};
        vecs[4] = '{key: 64'h0000000000000000, din: 64'h0000000000000000, enc: 1'b1, exp: 64'h8CA64DE9C1B123A7};
        vecs[5] = '{key: 64'h0101010101010101, din: 64'h0000000000000000, enc: 1'b1, exp: 64'h8CA64DE9C1B123A7};

        rst = 1'b1; start = 1'b0; enc1_dec0 = 1'b0; in_blk = '0; key = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", out, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start pulsed and inputs scrambled mid-run must not disturb vector 3.
        @(negedge clk);
        kick(vecs[2]);
        wait_done("ignored start", vecs[2].exp, 5);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk("ignored start extra done", 64'(pulses), 64'd0);
        chk("ignored start out held", out, vecs[2].exp);
        chk("ignored start busy", 64'(busy), 64'd0);

        // Back-to-back: second start raised during the done cycle.
        @(negedge clk);
        kick(vecs[2]);
        wait_done("b2b first", vecs[2].exp, 0);
        kick(vecs[3]);
        wait_done("b2b second", vecs[3].exp, 0);
        @(posedge clk); #1;
        chk("b2b done drop", 64'(done), 64'd0);

        // Abort with reset around round 8.
        @(negedge clk);
        kick(vecs[0]);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort out", out, 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("abort no done", 64'(pulses), 64'd0);
        chk("abort out stays", out, 64'd0);
        run_op(vecs[0], "after abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
